// File: rtl/uart_reg_ctrl.sv
// UART byte-command to register-bus bridge: write = cmd+data, read = cmd then reply byte.
// Optional GET_DATA inter-byte timeout enabled by defining UART_REG_CTRL_TIMEOUT_EN.
module uart_reg_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       uart_rx_valid,
  input  logic [7:0] uart_rx_data,
  input  logic       uart_tx_busy,
  output logic       uart_tx_en,
  output logic [7:0] uart_tx_data,
  output logic [6:0] reg_addr,
  output logic       reg_wr_en,
  output logic [7:0] reg_wdata,
  output logic       reg_rd_en,
  input  logic [7:0] reg_rdata,
  output logic       err_overrun
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 24'hFFFFFF) begin : g_bad_cfg
    $error("TIMEOUT_CYCLES out of range");
  end

  typedef enum logic [2:0] {
    IDLE,
    GET_DATA,
    WRITE,
    READ,
    READ_CAP,
    TX_WAIT
  } state_t;

  state_t state;

  logic busy_st;

  assign busy_st = (state == WRITE) || (state == READ) ||
                   (state == READ_CAP) || (state == TX_WAIT);

  // Strobes decode straight from the state register so they are mutually
  // exclusive; tx_en also needs busy so it can fire in the first free cycle.
  assign reg_wr_en  = (state == WRITE);
  assign reg_rd_en  = (state == READ);
  assign uart_tx_en = (state == TX_WAIT) && !uart_tx_busy;

`ifdef UART_REG_CTRL_TIMEOUT_EN
  localparam logic [23:0] TO_LAST = 24'(TIMEOUT_CYCLES - 1);

  logic [23:0] to_cnt;
  logic        to_hit;

  assign to_hit = (to_cnt == TO_LAST);
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      reg_addr     <= '0;
      reg_wdata    <= '0;
      uart_tx_data <= '0;
      err_overrun  <= 1'b0;
`ifdef UART_REG_CTRL_TIMEOUT_EN
      to_cnt       <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (uart_rx_valid) begin
            reg_addr <= uart_rx_data[6:0];
            state    <= uart_rx_data[7] ? GET_DATA : READ;
`ifdef UART_REG_CTRL_TIMEOUT_EN
            to_cnt   <= '0;
`endif
          end
        end
        GET_DATA: begin
          if (uart_rx_valid) begin
            reg_wdata <= uart_rx_data;
            state     <= WRITE;
          end
`ifdef UART_REG_CTRL_TIMEOUT_EN
          else if (to_hit) begin
            state  <= IDLE;
          end else begin
            to_cnt <= to_cnt + 24'd1;
          end
`endif
        end
        WRITE:    state <= IDLE;
        READ:     state <= READ_CAP;
        READ_CAP: begin
          uart_tx_data <= reg_rdata;
          state        <= TX_WAIT;
        end
        TX_WAIT: begin
          if (!uart_tx_busy) state <= IDLE;
        end
        default:  state <= IDLE;
      endcase

      if (uart_rx_valid && busy_st) err_overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_reg_ctrl.sv
// Directed bench for uart_reg_ctrl: write, read, busy stall, overrun,
// timeout (or indefinite wait) and mid-transaction reset.
module tb_uart_reg_ctrl;

  logic       clk = 1'b0;
  logic       resetn;
  logic       uart_rx_valid;
  logic [7:0] uart_rx_data;
  logic       uart_tx_busy;
  logic       uart_tx_en;
  logic [7:0] uart_tx_data;
  logic [6:0] reg_addr;
  logic       reg_wr_en;
  logic [7:0] reg_wdata;
  logic       reg_rd_en;
  logic [7:0] reg_rdata;
  logic       err_overrun;

  int n_chk = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int tx_cnt = 0;
  int excl = 0;
  int w0, r0, t0;

  always #5 clk = ~clk;

  uart_reg_ctrl #(.TIMEOUT_CYCLES(100)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .uart_rx_valid(uart_rx_valid),
    .uart_rx_data (uart_rx_data),
    .uart_tx_busy (uart_tx_busy),
    .uart_tx_en   (uart_tx_en),
    .uart_tx_data (uart_tx_data),
    .reg_addr     (reg_addr),
    .reg_wr_en    (reg_wr_en),
    .reg_wdata    (reg_wdata),
    .reg_rd_en    (reg_rd_en),
    .reg_rdata    (reg_rdata),
    .err_overrun  (err_overrun)
  );

  always @(posedge clk) begin
    wr_cnt <= wr_cnt + int'(reg_wr_en);
    rd_cnt <= rd_cnt + int'(reg_rd_en);
    tx_cnt <= tx_cnt + int'(uart_tx_en);
    if (int'(reg_wr_en) + int'(reg_rd_en) + int'(uart_tx_en) > 1)
      excl <= excl + 1;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge: strobe covers the next posedge only.
  task automatic send(input logic [7:0] b);
    uart_rx_valid = 1'b1;
    uart_rx_data  = b;
    @(negedge clk);
    uart_rx_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn        = 1'b0;
    uart_rx_valid = 1'b0;
    uart_rx_data  = 8'h00;
    uart_tx_busy  = 1'b0;
    reg_rdata     = 8'h00;
    tick(3);
    check("rst_outs",
          {uart_tx_en, uart_tx_data, reg_addr, reg_wr_en,
           reg_wdata, reg_rd_en, err_overrun}, 0);
    resetn = 1'b1;
    tick(1);

    // write 0x3C to 0x05
    w0 = wr_cnt;
    send(8'h85);
    check("wr_cmd_noen", reg_wr_en, 0);
    check("wr_cmd_addr", reg_addr, 7'h05);
    send(8'h3C);
    check("wr_en", reg_wr_en, 1);
    check("wr_addr", reg_addr, 7'h05);
    check("wr_data", reg_wdata, 8'h3C);
    tick(1);
    check("wr_en_off", reg_wr_en, 0);
    check("wr_data_hold", reg_wdata, 8'h3C);
    check("wr_pulses", wr_cnt - w0, 1);

    // read 0x12 -> 0xA7
    reg_rdata = 8'hA7;
    r0 = rd_cnt;
    t0 = tx_cnt;
    send(8'h12);
    check("rd_en", reg_rd_en, 1);
    check("rd_addr", reg_addr, 7'h12);
    tick(1);
    check("rd_cap_strobes", {reg_rd_en, uart_tx_en}, 0);
    tick(1);
    check("rd_tx_en", uart_tx_en, 1);
    check("rd_tx_data", uart_tx_data, 8'hA7);
    tick(1);
    check("rd_tx_off", uart_tx_en, 0);
    check("rd_tx_hold", uart_tx_data, 8'hA7);
    check("rd_pulses", rd_cnt - r0, 1);
    check("rd_tx_pulses", tx_cnt - t0, 1);

    // read 0x01 stalled by busy
    uart_tx_busy = 1'b1;
    reg_rdata    = 8'h5E;
    t0 = tx_cnt;
    send(8'h01);
    tick(50);
    check("busy_no_tx", tx_cnt - t0, 0);
    uart_tx_busy = 1'b0;
    #1;
    check("busy_tx_en", uart_tx_en, 1);
    check("busy_tx_data", uart_tx_data, 8'h5E);
    tick(1);
    check("busy_tx_off", uart_tx_en, 0);
    check("busy_tx_pulses", tx_cnt - t0, 1);

    // overrun: second byte during read
    check("ovr_clear", err_overrun, 0);
    reg_rdata = 8'h33;
    send(8'h12);
    send(8'h99);
    check("ovr_set", err_overrun, 1);
    check("ovr_rd_off", reg_rd_en, 0);
    tick(1);
    check("ovr_tx_en", uart_tx_en, 1);
    check("ovr_tx_data", uart_tx_data, 8'h33);
    tick(1);
    w0 = wr_cnt;
    r0 = rd_cnt;
    tick(3);
    check("ovr_dropped", (wr_cnt - w0) + (rd_cnt - r0), 0);
    check("ovr_sticky", err_overrun, 1);

`ifdef UART_REG_CTRL_TIMEOUT_EN
    // data on the boundary cycle wins
    send(8'h80);
    tick(99);
    send(8'h66);
    check("to_edge_wr", reg_wr_en, 1);
    check("to_edge_data", reg_wdata, 8'h66);
    check("to_edge_addr", reg_addr, 7'h00);
    tick(1);
    // one cycle later the write is abandoned
    w0 = wr_cnt;
    send(8'h80);
    tick(100);
    send(8'h55);
    check("to_no_wr", reg_wr_en, 0);
    check("to_rd_en", reg_rd_en, 1);
    check("to_rd_addr", reg_addr, 7'h55);
    tick(3);
    check("to_wr_pulses", wr_cnt - w0, 0);
`else
    send(8'h80);
    tick(100);
    send(8'h55);
    check("nto_wr", reg_wr_en, 1);
    check("nto_data", reg_wdata, 8'h55);
    check("nto_addr", reg_addr, 7'h00);
    tick(1);
`endif

    // reset in GET_DATA abandons the write
    w0 = wr_cnt;
    send(8'h80);
    resetn = 1'b0;
    #1;
    check("rst_async_err", err_overrun, 0);
    check("rst_async_regs", {reg_addr, reg_wdata}, 0);
    tick(1);
    resetn = 1'b1;
    send(8'h22);
    check("rst_rd_en", reg_rd_en, 1);
    check("rst_rd_addr", reg_addr, 7'h22);
    check("rst_no_wr", wr_cnt - w0, 0);
    tick(3);

    // reset with a pending reply drops it
    uart_tx_busy = 1'b1;
    reg_rdata    = 8'hC4;
    send(8'h12);
    tick(3);
    check("pend_cap", uart_tx_data, 8'hC4);
    t0 = tx_cnt;
    resetn = 1'b0;
    #1;
    check("pend_rst_data", uart_tx_data, 0);
    tick(1);
    uart_tx_busy = 1'b0;
    resetn = 1'b1;
    tick(5);
    check("pend_no_tx", tx_cnt - t0, 0);
    check("strobe_excl", excl, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_reg_ctrl.md
UART_REG_CTRL -- requirements
Module: uart_reg_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 1000000, inter-byte timeout in clk cycles (1 to 2^24-1).
REQ-002 The block SHALL have port clk, input, 1, top level system clock; all logic on its rising edge.
REQ-003 The block SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port uart_rx_valid, input, 1, one-cycle strobe when the UART receiver has a byte.
REQ-005 The block SHALL have port uart_rx_data, input, 8, received byte, valid with uart_rx_valid.
REQ-006 The block SHALL have port uart_tx_busy, input, 1, UART transmitter busy; no new byte accepted while high.
REQ-007 The block SHALL have port uart_tx_en, output, 1, one-cycle strobe to launch uart_tx_data.
REQ-008 The block SHALL have port uart_tx_data, output, 8, byte to transmit.
REQ-009 The block SHALL have port reg_addr, output, 7, register address for the current access.
REQ-010 The block SHALL have port reg_wr_en, output, 1, one-cycle register write strobe.
REQ-011 The block SHALL have port reg_wdata, output, 8, write data, valid with reg_wr_en.
REQ-012 The block SHALL have port reg_rd_en, output, 1, one-cycle register read strobe.
REQ-013 The block SHALL have port reg_rdata, input, 8, read data, valid the cycle after reg_rd_en.
REQ-014 The block SHALL have port err_overrun, output, 1, sticky flag: a byte arrived while not accepting.

Function
REQ-015 Command byte format SHALL be: bit7 = 1 write, 0 read; bits[6:0] = register address.
REQ-016 States SHALL be IDLE, GET_DATA, WRITE, READ, READ_CAP, TX_WAIT.
REQ-017 IDLE + uart_rx_valid SHALL latch bits[6:0] into reg_addr, next state GET_DATA if bit7=1, else READ.
REQ-018 GET_DATA + uart_rx_valid SHALL latch uart_rx_data into reg_wdata and go to WRITE.
REQ-019 WRITE SHALL assert reg_wr_en for exactly one cycle (the cycle after the data byte strobe), then go to IDLE.
REQ-020 READ SHALL assert reg_rd_en for exactly one cycle (the cycle after the command strobe), then go to READ_CAP.
REQ-021 READ_CAP SHALL capture reg_rdata into uart_tx_data, then go to TX_WAIT.
REQ-022 TX_WAIT SHALL pulse uart_tx_en for one cycle in the first cycle uart_tx_busy is low, then go to IDLE; minimum read latency command strobe to uart_tx_en = 3 cycles.
REQ-023 uart_rx_valid in WRITE, READ, READ_CAP or TX_WAIT SHALL drop the byte, set err_overrun, and not change state.
REQ-024 reg_addr, reg_wdata, uart_tx_data SHALL hold their last values outside their strobes.
REQ-025 reg_wr_en, reg_rd_en and uart_tx_en SHALL never be high in the same cycle.

Reset
REQ-026 resetn low SHALL asynchronously force state IDLE, all outputs 0, err_overrun 0, timeout counter 0.
REQ-027 Reset mid-transaction SHALL abandon it with no strobe issued; a pending read is not transmitted.
REQ-028 Leaving reset SHALL be synchronous; the first byte after release is treated as a command.

Configuration
REQ-029 With macro UART_REG_CTRL_TIMEOUT_EN defined, a 24-bit counter SHALL clear on entering GET_DATA, increment each GET_DATA cycle without uart_rx_valid, and on reaching TIMEOUT_CYCLES return to IDLE with no write.
REQ-030 With UART_REG_CTRL_TIMEOUT_EN undefined, no counter SHALL exist and GET_DATA SHALL wait indefinitely.
REQ-031 A data byte arriving in the same cycle the count reaches TIMEOUT_CYCLES SHALL be accepted (data wins).

Verification
REQ-032 Rx 0x85 then 0x3C -> one reg_wr_en pulse with reg_addr=0x05, reg_wdata=0x3C, cycle after second strobe.
REQ-033 Rx 0x12, reg_rdata=0xA7 -> reg_rd_en with reg_addr=0x12, then uart_tx_en with uart_tx_data=0xA7 3 cycles after strobe.
REQ-034 Read of 0x01 with uart_tx_busy high 50 cycles -> uart_tx_en the first cycle busy is low, exactly one pulse.
REQ-035 Rx 0x12 then another byte 1 cycle later -> second byte dropped, err_overrun=1 until reset.
REQ-036 Macro defined, TIMEOUT_CYCLES=100: rx 0x80, idle 100 cycles, rx 0x55 -> no write; 0x55 decoded as read of 0x55.
REQ-037 Rx 0x80, resetn low 1 cycle, rx 0x22 -> no write; 0x22 treated as read command of address 0x22.
